// File: rtl/rps_pkg.sv
// rps_pkg: shared encodings for the rock-paper-scissors match engine.
package rps_pkg;

    // Player move encoding as seen on pX_move.
    typedef enum logic [1:0] {
        MV_NONE     = 2'b00,
        MV_ROCK     = 2'b01,
        MV_PAPER    = 2'b10,
        MV_SCISSORS = 2'b11
    } move_t;

    // Round outcome, same encoding as the result output.
    typedef enum logic [1:0] {
        RES_TIE = 2'b00,
        RES_P1  = 2'b01,
        RES_P2  = 2'b10
    } result_t;

    // Match engine control states.
    typedef enum logic [1:0] {
        ST_COLLECT = 2'b00,
        ST_RESOLVE = 2'b01,
        ST_OVER    = 2'b10
    } state_t;

endpackage

// File: rtl/rps_judge.sv
// rps_judge: combinational two-player round judge (move A vs move B).
module rps_judge
    import rps_pkg::*;
(
    input  logic [1:0] a_move_i,
    input  logic [1:0] b_move_i,
    output logic [1:0] result_o
);

    move_t a_move;
    move_t b_move;

    assign a_move = move_t'(a_move_i);
    assign b_move = move_t'(b_move_i);

    // Rock beats scissors, paper beats rock, scissors beats paper; NONE never scores.
    always_comb begin
        result_o = RES_TIE;
        if (a_move != MV_NONE && b_move != MV_NONE && a_move != b_move) begin
            case (a_move)
                MV_ROCK:     result_o = (b_move == MV_SCISSORS) ? RES_P1 : RES_P2;
                MV_PAPER:    result_o = (b_move == MV_ROCK)     ? RES_P1 : RES_P2;
                MV_SCISSORS: result_o = (b_move == MV_PAPER)    ? RES_P1 : RES_P2;
                default:     result_o = RES_TIE;
            endcase
        end
    end

endmodule

// File: rtl/rps_match_engine.sv
// rps_match_engine: collects one move per player over valid/ready, resolves
// rounds, keeps scores/ties and ends the match at WIN_SCORE.
// Optional macro RPS_TIMEOUT_EN: forfeit a round when only one player has
// moved for TIMEOUT_CYC cycles.
module rps_match_engine
    import rps_pkg::*;
#(
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned WIN_SCORE   = 3,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_match,
    input  logic               p1_valid,
    input  logic [1:0]         p1_move,
    output logic               p1_ready,
    input  logic               p2_valid,
    input  logic [1:0]         p2_move,
    output logic               p2_ready,
    output logic [1:0]         result,
    output logic               round_done,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [SCORE_W-1:0] tie_count,
    output logic               match_over,
    output logic [1:0]         match_winner,
    output logic               forfeit
);

    // Elaboration-time parameter sanity.
    if (WIN_SCORE < 1 || WIN_SCORE > (2**SCORE_W) - 1) begin : g_bad_win_score
        $error("rps_match_engine: WIN_SCORE outside 1 .. 2**SCORE_W-1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("rps_match_engine: TIMEOUT_CYC must be at least 1");
    end

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] TIE_MAX = '1;

    state_t             state_q;
    logic               lock1_q, lock2_q;
    move_t              move1_q, move2_q;
    logic [SCORE_W-1:0] score1_q, score2_q, tie_q;
    result_t            result_q;
    result_t            winner_q;
    logic               round_done_q;
    logic               match_over_q;
    logic               p1_ready_q, p2_ready_q;

    logic               xfer1, xfer2;
    logic               lock1_d, lock2_d;
    logic               tmo_hit;
    logic               forfeit_pend;
    logic [1:0]         judge_raw;
    result_t            round_res_d;
    logic [SCORE_W-1:0] score1_d, score2_d, tie_d;
    logic               win_d;

    rps_judge u_judge (
        .a_move_i (move1_q),
        .b_move_i (move2_q),
        .result_o (judge_raw)
    );

    // Handshake decode and the outcome that RESOLVE would commit this cycle.
    always_comb begin
        xfer1   = p1_valid && p1_ready_q && (p1_move != MV_NONE);
        xfer2   = p2_valid && p2_ready_q && (p2_move != MV_NONE);
        lock1_d = lock1_q | xfer1;
        lock2_d = lock2_q | xfer2;

        // A forfeited round goes to whichever player did lock a move.
        if (forfeit_pend) begin
            round_res_d = lock1_q ? RES_P1 : RES_P2;
        end else begin
            round_res_d = result_t'(judge_raw);
        end

        score1_d = (round_res_d == RES_P1) ? score1_q + SCORE_W'(1) : score1_q;
        score2_d = (round_res_d == RES_P2) ? score2_q + SCORE_W'(1) : score2_q;
        tie_d    = (round_res_d == RES_TIE && tie_q != TIE_MAX) ? tie_q + SCORE_W'(1) : tie_q;
        win_d    = (score1_d == WIN_VAL) || (score2_d == WIN_VAL);
    end

    // Match FSM with registered outputs; ready is precomputed for the next state.
    always_ff @(posedge clk) begin
        if (rst || new_match) begin
            state_q      <= ST_COLLECT;
            lock1_q      <= 1'b0;
            lock2_q      <= 1'b0;
            move1_q      <= MV_NONE;
            move2_q      <= MV_NONE;
            score1_q     <= '0;
            score2_q     <= '0;
            tie_q        <= '0;
            result_q     <= RES_TIE;
            winner_q     <= RES_TIE;
            round_done_q <= 1'b0;
            match_over_q <= 1'b0;
            p1_ready_q   <= 1'b1;
            p2_ready_q   <= 1'b1;
        end else begin
            round_done_q <= 1'b0;
            case (state_q)
                ST_COLLECT: begin
                    if (xfer1) move1_q <= move_t'(p1_move);
                    if (xfer2) move2_q <= move_t'(p2_move);
                    lock1_q <= lock1_d;
                    lock2_q <= lock2_d;
                    if ((lock1_d && lock2_d) || tmo_hit) begin
                        state_q    <= ST_RESOLVE;
                        p1_ready_q <= 1'b0;
                        p2_ready_q <= 1'b0;
                    end else begin
                        p1_ready_q <= !lock1_d;
                        p2_ready_q <= !lock2_d;
                    end
                end
                ST_RESOLVE: begin
                    result_q     <= round_res_d;
                    score1_q     <= score1_d;
                    score2_q     <= score2_d;
                    tie_q        <= tie_d;
                    round_done_q <= 1'b1;
                    lock1_q      <= 1'b0;
                    lock2_q      <= 1'b0;
                    if (win_d) begin
                        state_q      <= ST_OVER;
                        match_over_q <= 1'b1;
                        winner_q     <= round_res_d;
                        p1_ready_q   <= 1'b0;
                        p2_ready_q   <= 1'b0;
                    end else begin
                        state_q    <= ST_COLLECT;
                        p1_ready_q <= 1'b1;
                        p2_ready_q <= 1'b1;
                    end
                end
                ST_OVER: begin
                    p1_ready_q <= 1'b0;
                    p2_ready_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_COLLECT;
                    p1_ready_q <= 1'b1;
                    p2_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef RPS_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;
    logic             forfeit_q;

    // Fires on the edge where a lone lock has waited TIMEOUT_CYC cycles and the
    // other player is still not transferring.
    assign tmo_hit = (state_q == ST_COLLECT) && (lock1_q ^ lock2_q)
                     && (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) && !(lock1_d && lock2_d);
    assign forfeit_pend = pend_q;
    assign forfeit      = forfeit_q;

    // Lone-lock wait counter and forfeit bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || new_match) begin
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            forfeit_q <= 1'b0;
        end else begin
            forfeit_q <= 1'b0;
            case (state_q)
                ST_COLLECT: begin
                    if (tmo_hit) begin
                        pend_q <= 1'b1;
                        cnt_q  <= '0;
                    end else if (lock1_q ^ lock2_q) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q <= '0;
                    end
                end
                ST_RESOLVE: begin
                    forfeit_q <= pend_q;
                    pend_q    <= 1'b0;
                    cnt_q     <= '0;
                end
                default: begin
                    cnt_q  <= '0;
                    pend_q <= 1'b0;
                end
            endcase
        end
    end
`else
    assign tmo_hit      = 1'b0;
    assign forfeit_pend = 1'b0;
    assign forfeit      = 1'b0;
`endif

    assign p1_ready     = p1_ready_q;
    assign p2_ready     = p2_ready_q;
    assign result       = result_q;
    assign round_done   = round_done_q;
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign tie_count    = tie_q;
    assign match_over   = match_over_q;
    assign match_winner = winner_q;

endmodule

// File: tb/tb_rps_match_engine.sv
// tb_rps_match_engine: table-driven + scoreboard bench for rps_match_engine.
module tb_rps_match_engine;

    localparam int unsigned SW  = 4;
    localparam int unsigned WIN = 3;
    localparam int unsigned TMO = 8;

    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] P = 2'b10;
    localparam logic [1:0] S = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          new_match = 1'b0;
    logic          p1_valid = 1'b0, p2_valid = 1'b0;
    logic [1:0]    p1_move = 2'b00, p2_move = 2'b00;
    logic          p1_ready, p2_ready;
    logic [1:0]    result;
    logic          round_done;
    logic [SW-1:0] score1, score2, tie_count;
    logic          match_over;
    logic [1:0]    match_winner;
    logic          forfeit;

    always #5 clk = ~clk;

    rps_match_engine #(.SCORE_W(SW), .WIN_SCORE(WIN), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .new_match(new_match),
        .p1_valid(p1_valid), .p1_move(p1_move), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_move(p2_move), .p2_ready(p2_ready),
        .result(result), .round_done(round_done),
        .score1(score1), .score2(score2), .tie_count(tie_count),
        .match_over(match_over), .match_winner(match_winner), .forfeit(forfeit)
    );

    typedef struct {
        int res;
        int s1;
        int s2;
        int tie;
        int fft;
    } exp_t;

    typedef struct {
        logic [1:0] m1;
        logic [1:0] m2;
        int         res;
    } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   m_s1 = 0, m_s2 = 0, m_tie = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_s1 = 0; m_s2 = 0; m_tie = 0;
        sbq.delete();
    endtask

    // Push the expected post-round state when a round's stimulus is driven.
    task automatic expect_round(input int res, input int fft);
        exp_t e;
        if (res == 1) m_s1++;
        if (res == 2) m_s2++;
        if (res == 0 && m_tie < 15) m_tie++;
        e.res = res; e.s1 = m_s1; e.s2 = m_s2; e.tie = m_tie; e.fft = fft;
        sbq.push_back(e);
    endtask

    // Wait (bounded) for round_done, then pop and compare.
    task automatic await_round(input string name);
        int   n = 0;
        exp_t e;
        while (!round_done && n < 20) begin
            tick();
            n++;
        end
        if (!round_done) begin
            chk({name, "_round_timeout"}, 0, 1);
        end else if (sbq.size() == 0) begin
            chk({name, "_unexpected_round"}, 1, 0);
        end else begin
            e = sbq.pop_front();
            chk({name, "_result"},  int'(result),    e.res);
            chk({name, "_score1"},  int'(score1),    e.s1);
            chk({name, "_score2"},  int'(score2),    e.s2);
            chk({name, "_ties"},    int'(tie_count), e.tie);
            chk({name, "_forfeit"}, int'(forfeit),   e.fft);
        end
    endtask

    task automatic play(input logic [1:0] m1, input logic [1:0] m2, input int res, input string name);
        p1_valid = 1'b1; p1_move = m1;
        p2_valid = 1'b1; p2_move = m2;
        expect_round(res, 0);
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0; p1_move = 2'b00; p2_move = 2'b00;
        await_round(name);
    endtask

    task automatic clr_match();
        new_match = 1'b1;
        tick();
        new_match = 1'b0;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        vt[0] = '{R, R, 0}; vt[1] = '{R, P, 2}; vt[2] = '{R, S, 1};
        vt[3] = '{P, R, 1}; vt[4] = '{P, P, 0}; vt[5] = '{P, S, 2};
        vt[6] = '{S, R, 2}; vt[7] = '{S, P, 1}; vt[8] = '{S, S, 0};

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_p1_ready", int'(p1_ready), 1);
        chk("rst_p2_ready", int'(p2_ready), 1);
        chk("rst_result", int'(result), 0);
        chk("rst_round_done", int'(round_done), 0);
        chk("rst_score1", int'(score1), 0);
        chk("rst_score2", int'(score2), 0);
        chk("rst_ties", int'(tie_count), 0);
        chk("rst_over", int'(match_over), 0);
        chk("rst_winner", int'(match_winner), 0);
        chk("rst_forfeit", int'(forfeit), 0);

        // Same-cycle moves: exact one-cycle resolve latency
        p1_valid = 1'b1; p1_move = R; p2_valid = 1'b1; p2_move = S;
        expect_round(1, 0);
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        chk("lat_ready_low", int'(p1_ready), 0);
        chk("lat_no_done_yet", int'(round_done), 0);
        tick();
        chk("lat_done", int'(round_done), 1);
        await_round("lat");
        tick();
        chk("lat_done_pulse", int'(round_done), 0);
        chk("lat_ready_back", int'(p1_ready), 1);

        // Full move-pair table; restart the match whenever someone wins
        clr_match();
        for (int i = 0; i < 9; i++) begin
            play(vt[i].m1, vt[i].m2, vt[i].res, $sformatf("vec%0d", i));
            if (m_s1 == int'(WIN) || m_s2 == int'(WIN)) begin
                chk($sformatf("vec%0d_over", i), int'(match_over), 1);
                chk($sformatf("vec%0d_winner", i), int'(match_winner), (m_s1 == int'(WIN)) ? 1 : 2);
                tick();
                clr_match();
            end else begin
                chk($sformatf("vec%0d_not_over", i), int'(match_over), 0);
            end
        end

        // Staggered moves with a NONE strobe that must be ignored
        clr_match();
        p1_valid = 1'b1; p1_move = P;
        tick();
        p1_valid = 1'b0;
        chk("stag_p1_locked", int'(p1_ready), 0);
        chk("stag_p2_open", int'(p2_ready), 1);
        p2_valid = 1'b1; p2_move = 2'b00;
        tick();
        p2_valid = 1'b0;
        chk("stag_none_ignored", int'(p2_ready), 1);
        chk("stag_no_round", int'(round_done), 0);
        tick();
        p2_valid = 1'b1; p2_move = R;
        expect_round(1, 0);
        tick();
        p2_valid = 1'b0; p2_move = 2'b00;
        chk("stag_p2_locked", int'(p2_ready), 0);
        await_round("stag");

        // Tie counter saturates at all-ones
        clr_match();
        for (int i = 0; i < 17; i++) play(S, S, 0, $sformatf("tie%0d", i));
        chk("tie_sat", int'(tie_count), 15);

        // P2 wins the match; OVER ignores moves until new_match
        clr_match();
        for (int i = 0; i < 3; i++) play(R, P, 2, $sformatf("p2win%0d", i));
        chk("over_flag", int'(match_over), 1);
        chk("over_winner", int'(match_winner), 2);
        chk("over_p1_ready", int'(p1_ready), 0);
        chk("over_p2_ready", int'(p2_ready), 0);
        p1_valid = 1'b1; p1_move = S; p2_valid = 1'b1; p2_move = P;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("over_hold_done%0d", i), int'(round_done), 0);
        end
        p1_valid = 1'b0; p2_valid = 1'b0;
        chk("over_hold_score2", int'(score2), 3);
        chk("over_hold_result", int'(result), 2);
        clr_match();
        chk("nm_over", int'(match_over), 0);
        chk("nm_winner", int'(match_winner), 0);
        chk("nm_score2", int'(score2), 0);
        chk("nm_result", int'(result), 0);
        chk("nm_ready", int'(p1_ready & p2_ready), 1);

        // rst during RESOLVE discards the round
        play(R, S, 1, "pre_rst");
        p1_valid = 1'b1; p1_move = P; p2_valid = 1'b1; p2_move = R;
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        chk("rstres_done", int'(round_done), 0);
        chk("rstres_score1", int'(score1), 0);
        chk("rstres_ready", int'(p1_ready & p2_ready), 1);
        tick();
        chk("rstres_done_later", int'(round_done), 0);

        // new_match during RESOLVE discards the round
        play(R, S, 1, "pre_nm");
        p1_valid = 1'b1; p1_move = P; p2_valid = 1'b1; p2_move = R;
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        clr_match();
        chk("nmres_done", int'(round_done), 0);
        chk("nmres_score1", int'(score1), 0);
        chk("nmres_ready", int'(p1_ready & p2_ready), 1);
        tick();
        chk("nmres_done_later", int'(round_done), 0);

`ifdef RPS_TIMEOUT_EN
        // Lone P1 move forfeits after TMO cycles
        clr_match();
        p1_valid = 1'b1; p1_move = R;
        expect_round(1, 1);
        tick();
        p1_valid = 1'b0;
        for (int k = 1; k <= int'(TMO); k++) begin
            tick();
            chk($sformatf("tmo_early%0d", k), int'(round_done), 0);
        end
        tick();
        chk("tmo_done", int'(round_done), 1);
        await_round("tmo");

        // P2 arrives exactly on the timeout edge: ordinary round
        p1_valid = 1'b1; p1_move = R;
        tick();
        p1_valid = 1'b0;
        for (int k = 1; k < int'(TMO); k++) tick();
        p2_valid = 1'b1; p2_move = S;
        expect_round(1, 0);
        tick();
        p2_valid = 1'b0;
        tick();
        chk("tmo_edge_done", int'(round_done), 1);
        await_round("tmo_edge");
`endif

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rps_match_engine.md
Name: rps_match_engine

Overview:
- Clocked, parametrised successor to the rock-paper-scissors round judge.
- Collects one move per player through valid/ready handshakes and resolves each round on a clock edge.
- Keeps per-player scores, a tie counter and match status; a match ends when a player reaches WIN_SCORE.
- Outputs feed the existing result and score seven-segment decoders unchanged (result 2 bits, scores SCORE_W bits).

Parameters:
- SCORE_W, 4, width of each score register and of tie_count.
- WIN_SCORE, 3, points that end the match; legal range 1 .. 2**SCORE_W-1 (elaboration-time assertion).
- TIMEOUT_CYC, 1000, forfeit timeout in clock cycles; used only with RPS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- new_match  in  1  pulse; clears scores and starts a new match
- p1_valid  in  1  player 1 move strobe
- p1_move  in  2  player 1 move (rps_pkg encoding)
- p1_ready  out  1  player 1 may submit a move
- p2_valid  in  1  player 2 move strobe
- p2_move  in  2  player 2 move (rps_pkg encoding)
- p2_ready  out  1  player 2 may submit a move
- result  out  2  last round outcome: 00 tie/none, 01 P1 won, 10 P2 won
- round_done  out  1  one-cycle pulse when result/scores update
- score1  out  SCORE_W  player 1 score
- score2  out  SCORE_W  player 2 score
- tie_count  out  SCORE_W  ties in the current match, saturating
- match_over  out  1  high while in OVER
- match_winner  out  2  01 or 10 while match_over, else 00
- forfeit  out  1  pulse with round_done when the round was won by timeout

Behaviour:
- Reset: on rst=1 at a clock edge, the block enters COLLECT. All outputs except p1_ready/p2_ready reset to 0. Both locks are cleared, so p1_ready=p2_ready=1.
- Priority: rst, then new_match, then normal operation.
- new_match takes effect in any state: scores, tie_count, result, winner and locks clear, and the next state is COLLECT.
- Move encoding: 00 NONE, 01 ROCK, 10 PAPER, 11 SCISSORS.
- A transfer occurs when pX_valid && pX_ready && pX_move != NONE.
  - On a transfer, the move is latched and the player's lock is set.
  - NONE with valid asserted is ignored and no lock is set.
- pX_ready = (state==COLLECT) && !pX_locked. A locked move cannot be changed.
- Both players may transfer on the same edge.
- COLLECT -> RESOLVE on the edge after both locks are set.
- RESOLVE lasts one cycle. At its closing edge:
  - result, score and tie_count register; round_done pulses for 1 cycle; locks clear.
  - Wins: ROCK beats SCISSORS, PAPER beats ROCK, SCISSORS beats PAPER. Equal moves give result 00 and tie_count+1, saturating at all-ones.
- Latency: second lock set at edge N; result, scores and round_done are visible after edge N+1.
- If the updated score equals WIN_SCORE, next state is OVER and match_winner is set; otherwise next state is COLLECT.
- OVER: match_over=1, both ready signals 0, valids ignored, result and scores held until new_match or rst.
- Score never exceeds WIN_SCORE, so no wrap.
- Reset or new_match during RESOLVE discards the pending round: no score change and no round_done.

Optional Feature:
- Macro: RPS_TIMEOUT_EN.
- With the macro defined:
  - A counter starts when exactly one lock is set in COLLECT.
  - When it reaches TIMEOUT_CYC-1 with the other player still unlocked, the next state is RESOLVE. The locked player wins the point, forfeit pulses with round_done, and tie_count is unchanged.
  - The counter clears on entering RESOLVE, on rst and on new_match.
  - If the other lock arrives on the timeout edge, it counts as a normal round with no forfeit.
- Without the macro: no counter, forfeit is tied to 0, and COLLECT waits indefinitely.

Decomposition:
- rps_pkg: move_t (NONE/ROCK/PAPER/SCISSORS), result_t (TIE, P1, P2), state_t (COLLECT, RESOLVE, OVER).
- Sub-module rps_judge: combinational (move_t, move_t) -> result_t. It is shared with any future multi-player variant.

Test Plan:
- Reset then P1 ROCK, P2 SCISSORS in the same cycle -> one cycle later round_done=1, result=01, score1=1, score2=0.
- P1 PAPER at cycle 0; P2 valid with NONE at cycle 1, then ROCK at cycle 3 -> p2 NONE ignored, p1_ready=0 from cycle 1, resolve gives result=01.
- Two SCISSORS/SCISSORS rounds -> result=00 twice, tie_count=2, scores unchanged.
- P2 wins three rounds (WIN_SCORE=3) -> match_over=1, match_winner=10, ready low, extra valids ignored; new_match -> all zero, COLLECT.
- rst asserted during RESOLVE -> no round_done, scores 0; same with new_match.
- RPS_TIMEOUT_EN, TIMEOUT_CYC=8: P1 ROCK only -> after 8 cycles forfeit=1, round_done=1, result=01, score1=1; P2 arriving exactly at the timeout edge -> normal resolve, forfeit=0.
